// File: rtl/vce_bus_master.sv
// vce_bus_master
// CPU-side MMIO initiator for the HuC6260 VCE register port. A request
// (write CR, write color, read color, reserved) is broken into one or four
// register accesses. Each access is a strobe of STROBE_CYC cycles, followed by
// RECOVER_CYC cycles with every strobe high. The VCE edge detector samples at
// the MMIO rate, and these lengths let it see each access exactly once.
//
// Ports:
//   clock, reset         master clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (accept on valid & ready)
//   req_op/index/data    operation, CRAM index, write data
//   rsp_valid/rsp_data   one-cycle completion pulse, read result
//   A, D                 VCE register select and bidirectional data bus
//   RD_n, WR_n, CS_n     active-low strobes and chip select
module vce_bus_master #(
  parameter int STROBE_CYC  = 4,
  parameter int RECOVER_CYC = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [8:0] req_index,
  input  logic [8:0] req_data,
  output logic       rsp_valid,
  output logic [8:0] rsp_data,
  output logic [2:0] A,
  inout  wire  [7:0] D,
  output logic       RD_n,
  output logic       WR_n,
  output logic       CS_n
);

  if (STROBE_CYC < 3 || STROBE_CYC > 15) begin : g_bad_strobe
    $error("vce_bus_master: STROBE_CYC must be in 3..15");
  end
  if (RECOVER_CYC < 3 || RECOVER_CYC > 15) begin : g_bad_recover
    $error("vce_bus_master: RECOVER_CYC must be in 3..15");
  end

  localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYC - 1);

  localparam logic [1:0] OP_WR_CR    = 2'd0;
  localparam logic [1:0] OP_WR_COLOR = 2'd1;
  localparam logic [1:0] OP_RD_COLOR = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Bus view of one step of a request.
  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       is_read;
  } access_t;

  // Color ops walk A=2..5: index low/high, then data low/high (written for
  // op 1, read back for op 2). Op 0 is a single CR write at A=0.
  function automatic access_t decode_step(input logic [1:0] op, input logic [1:0] step,
                                          input logic [8:0] index, input logic [8:0] data);
    access_t acc;
    acc.is_read = 1'b0;
    if (op == OP_WR_CR) begin
      acc.addr  = 3'd0;
      acc.wdata = data[7:0];
    end else begin
      acc.addr = 3'd2 + {1'b0, step};
      case (step)
        2'd0:    acc.wdata = index[7:0];
        2'd1:    acc.wdata = {7'b0, index[8]};
        2'd2:    acc.wdata = data[7:0];
        default: acc.wdata = {7'b0, data[8]};
      endcase
      acc.is_read = (op == OP_RD_COLOR) && step[1];
    end
    return acc;
  endfunction

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [1:0] step_reg, step_next;
  logic [1:0] op_reg, op_next;
  logic [8:0] index_reg, index_next;
  logic [8:0] data_reg, data_next;
  logic [7:0] rd_lo_reg, rd_lo_next;
  logic       rd_hi_reg, rd_hi_next;
  logic       rsp_valid_reg, rsp_valid_next;
  logic [8:0] rsp_data_reg, rsp_data_next;
  logic [2:0] a_reg, a_next;
  logic [7:0] dout_reg, dout_next;
  logic       drive_reg, drive_next;
  logic       rd_n_reg, rd_n_next;
  logic       wr_n_reg, wr_n_next;
  logic       cs_n_reg, cs_n_next;

  access_t    acc_next;
  logic       strobe_next;
  logic       cur_is_read;
  logic [1:0] last_step;

  assign cur_is_read = (op_reg == OP_RD_COLOR) && step_reg[1];
  assign last_step   = (op_reg == OP_WR_CR) ? 2'd0 : 2'd3;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    step_next      = step_reg;
    op_next        = op_reg;
    index_next     = index_reg;
    data_next      = data_reg;
    rd_lo_next     = rd_lo_reg;
    rd_hi_next     = rd_hi_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;

    case (state_reg)
      IDLE: begin
        // req_ready is IDLE & ~reset; reset itself overrides in the register.
        if (req_valid) begin
          op_next    = req_op;
          index_next = req_index;
          data_next  = req_data;
          step_next  = 2'd0;
          cnt_next   = 4'd0;
          if (req_op == OP_RSVD) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = 9'd0;
          end else begin
            state_next = STROBE;
          end
        end
      end
      STROBE: begin
        if (cnt_reg == STROBE_LAST) begin
          cnt_next   = 4'd0;
          state_next = RECOVER;
          // Capture on the edge that ends the last low cycle of the read.
          if (cur_is_read) begin
            if (step_reg == 2'd2) rd_lo_next = D;
            else                  rd_hi_next = D[0];
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      RECOVER: begin
        if (cnt_reg == RECOVER_LAST) begin
          cnt_next = 4'd0;
          if (step_reg == last_step) begin
            state_next     = IDLE;
            rsp_valid_next = 1'b1;
            rsp_data_next  = (op_reg == OP_RD_COLOR) ? {rd_hi_reg, rd_lo_reg} : 9'd0;
          end else begin
            step_next  = step_reg + 2'd1;
            state_next = STROBE;
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Bus pins are registered from the next state so they change cleanly on
    // the clock edge; A and the data latch hold while strobes are high.
    acc_next    = decode_step(op_next, step_next, index_next, data_next);
    strobe_next = (state_next == STROBE);
    cs_n_next   = !strobe_next;
    wr_n_next   = !(strobe_next && !acc_next.is_read);
    rd_n_next   = !(strobe_next && acc_next.is_read);
    drive_next  = strobe_next && !acc_next.is_read;
    a_next      = strobe_next ? acc_next.addr  : a_reg;
    dout_next   = strobe_next ? acc_next.wdata : dout_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      step_reg      <= 2'd0;
      op_reg        <= 2'd0;
      index_reg     <= 9'd0;
      data_reg      <= 9'd0;
      rd_lo_reg     <= 8'd0;
      rd_hi_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 9'd0;
      a_reg         <= 3'd0;
      dout_reg      <= 8'd0;
      drive_reg     <= 1'b0;
      rd_n_reg      <= 1'b1;
      wr_n_reg      <= 1'b1;
      cs_n_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      step_reg      <= step_next;
      op_reg        <= op_next;
      index_reg     <= index_next;
      data_reg      <= data_next;
      rd_lo_reg     <= rd_lo_next;
      rd_hi_reg     <= rd_hi_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      a_reg         <= a_next;
      dout_reg      <= dout_next;
      drive_reg     <= drive_next;
      rd_n_reg      <= rd_n_next;
      wr_n_reg      <= wr_n_next;
      cs_n_reg      <= cs_n_next;
    end
  end

  assign req_ready = (state_reg == IDLE) && !reset;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign A         = a_reg;
  assign D         = drive_reg ? dout_reg : 8'bz;
  assign RD_n      = rd_n_reg;
  assign WR_n      = wr_n_reg;
  assign CS_n      = cs_n_reg;

endmodule

// File: doc/vce_bus_master.md
# vce_bus_master

CPU-side MMIO initiator that drives the HuC6260 VCE register port (A, D, RD_n, WR_n, CS_n) on behalf of a simple request/response interface. It sequences the multi-access register protocol for control-register writes, palette (CRAM) writes and palette reads. It stretches every strobe so the VCE's MMIO-rate edge detector, which samples once per 3 master clocks, sees each access exactly once. It sits between a palette loader or debug master and the VCE, on the same master clock.

## Interface
- STROBE_CYC, 4, master-clock cycles each RD_n/WR_n low pulse lasts; legal range 3..15; values below 3 raise a simulation $error.
- RECOVER_CYC, 4, master-clock cycles all strobes stay high after each pulse; legal range 3..15; values below 3 raise a simulation $error.
- clock  input  1  master clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE and not in reset; the request is accepted on a clock edge where req_valid & req_ready.
- req_op  input  2  0 = write CR, 1 = write color, 2 = read color, 3 = reserved.
- req_index  input  9  CRAM index (ops 1, 2).
- req_data  input  9  write data; for op 0 only bits [7:0] are used.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_data  output  9  read result (op 2); 0 for every other op.
- A  output  3  VCE register select.
- D  inout  8  data bus; driven only during write strobes, otherwise high-Z.
- RD_n, WR_n, CS_n  output  1 each  active-low strobes and chip select.

## Operation
- States: IDLE, STROBE, RECOVER.
  - IDLE → STROBE on accept.
  - STROBE → RECOVER after STROBE_CYC cycles.
  - RECOVER → STROBE (next step) or IDLE (last step) after RECOVER_CYC cycles.
- A request is latched at accept into op, index, data and a 2-bit step counter. Step sequences:
  - op 0: one write, A=0, D=data[7:0].
  - op 1: four writes:
    - A=2, D=index[7:0]
    - A=3, D={7'b0,index[8]}
    - A=4, D=data[7:0]
    - A=5, D={7'b0,data[8]}
  - op 2: two writes and two reads:
    - A=2, D=index[7:0] (write)
    - A=3, D={7'b0,index[8]} (write)
    - A=4 read: capture D into rsp_data[7:0]
    - A=5 read: capture D[0] into rsp_data[8]
  - op 3: accepted with no bus activity; rsp_valid pulses on the next cycle with rsp_data=0.
- During STROBE: CS_n=0; WR_n=0 for write steps or RD_n=0 for read steps; A is stable; D is driven only for write steps.
- During RECOVER: CS_n, RD_n and WR_n are all 1; D is high-Z; A holds its last value.
- Read capture occurs on the clock edge that ends the last STROBE cycle of the read step.
- On completion the block returns to IDLE and rsp_valid=1 for that one cycle. req_ready is also 1 in that cycle, so back-to-back requests are accepted with no extra idle cycle. The RECOVER phase guarantees at least RECOVER_CYC high cycles between consecutive strobes.
- rsp_data holds its last value until the next completion; non-read ops complete with 0.

## Timing
- Reset (synchronous): CS_n=RD_n=WR_n=1, A=0, D=Z, rsp_valid=0, rsp_data=0, req_ready=0, state IDLE, counters 0. req_ready rises in the first cycle after reset deasserts.
- Reset mid-operation: on the next edge strobes go high, D goes Z, the operation is abandoned and no rsp_valid is issued.
- Let P = STROBE_CYC + RECOVER_CYC. With accept at edge 0, strobes are low in cycles 1..STROBE_CYC of each step.
- rsp_valid cycle by op:
  - op 0: cycle P+1
  - ops 1 and 2: cycle 4P+1
  - op 3: cycle 1
- Defaults (P=8): op 0 completes at cycle 9, ops 1/2 at cycle 33.
- req_* inputs are ignored except on the accept edge.
- Counter width is 4 bits; the step counter wraps only through IDLE.

## Test plan
- Reset held 5 cycles → CS_n=RD_n=WR_n=1, D=Z, req_ready=0 during reset, 1 on the first post-reset cycle, rsp_valid never asserted.
- op 0, req_data=0x102 → one write with A=0, D=0x02, WR_n low exactly 4 cycles, CS_n low for the same cycles; rsp_valid at cycle 9, rsp_data=0.
- op 1, index 0x1A5, data 0x1C7 → writes (A2,0xA5), (A3,0x01), (A4,0xC7), (A5,0x01), each WR_n pulse 4 cycles with 4 high cycles between; rsp_valid at cycle 33. A VCE model's CRAM[0x1A5] reads back 0x1C7.
- op 2, index 0x010, bus model returning 0x3F at A=4 and 0x01 at A=5 → writes (A2,0x10), (A3,0x00), then two RD_n pulses with D=Z from the master; rsp_data=0x13F at cycle 33.
- req_valid held continuously with op 0 then op 1 queued → the second request is accepted in the rsp_valid cycle of the first, with at least 4 strobe-high cycles between the last op 0 strobe and the first op 1 strobe.
- Reset asserted during the 2nd STROBE cycle of step 3 of op 2 → strobes high and D=Z next edge, no rsp_valid, rsp_data=0; a fresh op 0 after reset completes normally at cycle 9.
